pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Instruction-fetch stage for the RV32I core. Holds the architectural PC, fetches
//  from instruction memory over a req/ack handshake, and presents idata/iaddr to the
//  decode and execute units (the B/J/I type units). On retire it consumes the next-PC
//  those units compute (iaddr_val), checks alignment, and steps the PC.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded on reset
//  TIMEOUT       16             max REQ cycles without imem_ack before fetch_fault (>=2)
// PORTS
//  clk            in   1   core clock, rising edge
//  reset          in   1   synchronous, active-high reset
//  imem_req       out  1   fetch request; held until imem_ack
//  imem_addr      out  32  fetch address (= pc); stable while imem_req=1
//  imem_ack       in   1   memory returns imem_rdata this cycle
//  imem_rdata     in   32  instruction word; valid only when imem_ack=1
//  instr_valid    out  1   idata/iaddr hold a fetched instruction
//  idata          out  32  instruction to decode
//  iaddr          out  32  PC of idata
//  instr_ready    in   1   core retires idata this cycle; iaddr_val is valid
//  iaddr_val      in   32  next PC from the branch/jump/sequential path
//  fetch_fault    out  1   sticky: imem_ack timeout
//  misalign_fault out  1   sticky: iaddr_val[1:0] != 0 on retire
//  fault_addr     out  32  offending address of the first fault
// BEHAVIOUR
//  Reset (sync, dominates all inputs): state=IDLE, pc=RESET_VECTOR, imem_req=0,
//   instr_valid=0, idata=NOP (32'h0000_0013), fetch_fault=0, misalign_fault=0,
//   fault_addr=0, timeout cnt=0.
//  FSM (fetch_state_e): IDLE, REQ, VALID, FAULT.
//  - IDLE: all outputs quiet; unconditionally -> REQ next cycle. imem_ack ignored.
//  - REQ: imem_req=1, imem_addr=pc. imem_ack sampled on the clock edge:
//     ack=1 -> idata<=imem_rdata, cnt<=0, -> VALID. Ack in the first REQ cycle (zero-wait) is legal.
//     ack=0 -> cnt++. When cnt==TIMEOUT-1 and ack=0 -> FAULT, fetch_fault<=1,
//     fault_addr<=pc. Ack on the timeout cycle wins (no fault).
//  - VALID: instr_valid=1, iaddr=pc, idata held stable, imem_req=0, imem_ack ignored.
//     instr_ready=1: iaddr_val[1:0]!=0 -> FAULT, misalign_fault<=1,
//     fault_addr<=iaddr_val, pc unchanged; else pc<=iaddr_val, -> REQ.
//     instr_ready=0: hold indefinitely.
//  - FAULT: imem_req=0, instr_valid=0; sticky until reset. Only the first fault is recorded.
//  Latency: retire edge -> imem_req on the next cycle. With zero-wait memory, throughput
//   is 1 instruction per 2 cycles.
//  Width rules: pc is 32 bit; no internal +4 (the core supplies pc+4 via iaddr_val);
//   wrap 32'hFFFF_FFFC->0 passes unchecked. cnt is $clog2(TIMEOUT) bits and saturates.
//  Reset mid-REQ: imem_req=0 after the edge; a late imem_ack is ignored (IDLE).
//  Outputs are registered; imem_addr/iaddr are driven directly from the pc register.
// STRUCTURE
//  riscv_pkg additions: typedef enum logic[1:0] fetch_state_e; localparam NOP_INSTR=32'h0000_0013.
//  RESET_VECTOR stays a module parameter. Single module; the timeout counter is inline,
//  with no sub-module. Instr_IO gains modport fetch_io_ports (idata, iaddr, iaddr_val,
//  instr_valid, instr_ready).
// TESTING
//  1 Reset 2 cycles -> imem_req=0, instr_valid=0, idata=00000013. Release -> cycle 1 IDLE,
//    cycle 2 imem_req=1 with imem_addr=0.
//  2 Zero-wait: ack with rdata=00A00093 in the first REQ cycle -> next cycle instr_valid=1,
//    idata=00A00093, iaddr=0. instr_ready with iaddr_val=4 -> next cycle imem_addr=4.
//  3 Taken BEQ: iaddr=0x0C, retire with iaddr_val=0xFC -> imem_addr=0xFC.
//    Not taken (iaddr_val=0x10) -> imem_addr=0x10.
//  4 Wait states: ack after 3 cycles -> imem_req high and imem_addr stable for 3 cycles,
//    instr_valid=0 until the cycle after ack. Hold instr_ready=0 for 5 cycles -> idata stable.
//  5 Timeout: no ack for 16 REQ cycles -> fetch_fault=1, fault_addr=pc, imem_req=0,
//    sticky until reset. Ack on cycle 16 -> no fault.
//  6 Misaligned: retire with iaddr_val=0x102 -> misalign_fault=1, fault_addr=0x102,
//    no further imem_req. Reset mid-REQ, then late ack -> ignored, refetch from 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core types and constants.
// Holds the fetch FSM encoding and the canonical NOP used by the fetch stage.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, fetches over a req/ack
// handshake, presents idata/iaddr to decode and steps the PC on retire.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] idata,
  output logic [31:0] iaddr,
  input  logic        instr_ready,
  input  logic [31:0] iaddr_val,
  output logic        fetch_fault,
  output logic        misalign_fault,
  output logic [31:0] fault_addr
);

  localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      idata_q, idata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic             fetch_fault_q, fetch_fault_d;
  logic             misalign_fault_q, misalign_fault_d;
  logic [31:0]      fault_addr_q, fault_addr_d;
  logic             fault_seen;

  assign fault_seen = fetch_fault_q | misalign_fault_q;

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    idata_d          = idata_q;
    cnt_d            = cnt_q;
    fetch_fault_d    = fetch_fault_q;
    misalign_fault_d = misalign_fault_q;
    fault_addr_d     = fault_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (imem_ack) begin
          idata_d = imem_rdata;
          cnt_d   = '0;
          state_d = ST_VALID;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = ST_FAULT;
          fetch_fault_d = 1'b1;
          if (!fault_seen) fault_addr_d = pc_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_VALID: begin
        if (instr_ready) begin
          if (is_word_aligned(iaddr_val)) begin
            pc_d    = iaddr_val;
            state_d = ST_REQ;
          end else begin
            state_d          = ST_FAULT;
            misalign_fault_d = 1'b1;
            if (!fault_seen) fault_addr_d = iaddr_val;
          end
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_d   = (state_d == ST_REQ);
    valid_d = (state_d == ST_VALID);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      pc_q             <= RESET_VECTOR;
      idata_q          <= NOP_INSTR;
      cnt_q            <= '0;
      req_q            <= 1'b0;
      valid_q          <= 1'b0;
      fetch_fault_q    <= 1'b0;
      misalign_fault_q <= 1'b0;
      fault_addr_q     <= 32'h0000_0000;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      idata_q          <= idata_d;
      cnt_q            <= cnt_d;
      req_q            <= req_d;
      valid_q          <= valid_d;
      fetch_fault_q    <= fetch_fault_d;
      misalign_fault_q <= misalign_fault_d;
      fault_addr_q     <= fault_addr_d;
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = pc_q;
  assign instr_valid    = valid_q;
  assign idata          = idata_q;
  assign iaddr          = pc_q;
  assign fetch_fault    = fetch_fault_q;
  assign misalign_fault = misalign_fault_q;
  assign fault_addr     = fault_addr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pc_fetch_unit;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_ready = 1'b0;
  logic [31:0] iaddr_val = '0;
  logic        imem_req, instr_valid, fetch_fault, misalign_fault;
  logic [31:0] imem_addr, idata, iaddr, fault_addr;

  int n_cmp = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .idata(idata), .iaddr(iaddr),
    .instr_ready(instr_ready), .iaddr_val(iaddr_val),
    .fetch_fault(fetch_fault), .misalign_fault(misalign_fault), .fault_addr(fault_addr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "waiting" for memory, "holding" an instruction, or
  // stopped by a fault; m_waited counts unanswered request cycles.
  logic [31:0] m_pc, m_idata, m_fa;
  logic        m_idle, m_req, m_valid, m_ff, m_mf;
  int          m_waited;

  always @(posedge clk) begin
    if (reset) begin
      m_pc <= 32'h0; m_idata <= NOP; m_fa <= 32'h0;
      m_idle <= 1'b1; m_req <= 1'b0; m_valid <= 1'b0;
      m_ff <= 1'b0; m_mf <= 1'b0; m_waited <= 0;
    end else if (m_ff || m_mf) begin
      m_req <= 1'b0;
    end else if (m_idle) begin
      m_idle <= 1'b0;
      m_req  <= 1'b1;
    end else if (m_req) begin
      if (imem_ack) begin
        m_idata <= imem_rdata; m_req <= 1'b0; m_valid <= 1'b1; m_waited <= 0;
      end else if (m_waited + 1 == TIMEOUT) begin
        m_ff <= 1'b1; m_fa <= m_pc; m_req <= 1'b0;
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (m_valid && instr_ready) begin
      m_valid <= 1'b0;
      if (iaddr_val % 4 != 0) begin
        m_mf <= 1'b1; m_fa <= iaddr_val;
      end else begin
        m_pc <= iaddr_val; m_req <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("imem_req",       32'(imem_req),       32'(m_req));
      check("imem_addr",      imem_addr,           m_pc);
      check("instr_valid",    32'(instr_valid),    32'(m_valid));
      check("idata",          idata,               m_idata);
      check("iaddr",          iaddr,               m_pc);
      check("fetch_fault",    32'(fetch_fault),    32'(m_ff));
      check("misalign_fault", 32'(misalign_fault), 32'(m_mf));
      check("fault_addr",     fault_addr,          m_fa);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Expects to be called while the unit is requesting.
  task automatic do_fetch(input logic [31:0] word, input int waits);
    logic [31:0] addr0;
    addr0 = imem_addr;
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      tick();
      check("wait_req",   32'(imem_req),    32'd1);
      check("wait_addr",  imem_addr,        addr0);
      check("wait_valid", 32'(instr_valid), 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    check("fetch_valid", 32'(instr_valid), 32'd1);
    check("fetch_idata", idata,            word);
    check("fetch_req",   32'(imem_req),    32'd0);
  endtask

  task automatic do_retire(input logic [31:0] next_pc);
    instr_ready = 1'b1; iaddr_val = next_pc;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int ack_pct;
    logic [31:0] rnd;

    repeat (2) tick();
    cmp_en = 1'b1;
    check("rst_req",   32'(imem_req),    32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_idata", idata,            NOP);
    reset = 1'b0;
    check("idle_req",  32'(imem_req),    32'd0);
    tick();
    check("first_req",  32'(imem_req), 32'd1);
    check("first_addr", imem_addr,     32'h0);

    do_fetch(32'h00A0_0093, 0);
    check("zw_iaddr", iaddr, 32'h0);
    do_retire(32'h4);
    check("seq_req",  32'(imem_req), 32'd1);
    check("seq_addr", imem_addr,     32'h4);

    do_fetch(32'h0040_0113, 0);
    do_retire(32'hC);
    do_fetch(32'h0020_8463, 0);
    check("beq_iaddr", iaddr, 32'hC);
    do_retire(32'hFC);
    check("taken_addr", imem_addr, 32'hFC);
    do_fetch(32'h0000_006F, 0);
    do_retire(32'hC);
    do_fetch(32'h0020_8463, 0);
    do_retire(32'h10);
    check("ntaken_addr", imem_addr, 32'h10);

    do_fetch(32'h1234_5678, 3);
    repeat (5) begin
      tick();
      check("hold_idata", idata,            32'h1234_5678);
      check("hold_valid", 32'(instr_valid), 32'd1);
    end
    do_retire(32'h20);

    imem_ack = 1'b0;
    repeat (TIMEOUT - 1) tick();
    check("to_pre_fault", 32'(fetch_fault), 32'd0);
    check("to_pre_req",   32'(imem_req),    32'd1);
    tick();
    check("to_fault", 32'(fetch_fault), 32'd1);
    check("to_faddr", fault_addr,       32'h20);
    check("to_req",   32'(imem_req),    32'd0);
    imem_ack = 1'b1;
    repeat (4) tick();
    imem_ack = 1'b0;
    check("to_sticky", 32'(fetch_fault), 32'd1);
    check("to_noreq",  32'(imem_req),    32'd0);

    do_reset();
    check("rst2_addr", imem_addr, 32'h0);
    repeat (TIMEOUT - 1) tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("late_ack_fault", 32'(fetch_fault), 32'd0);
    check("late_ack_valid", 32'(instr_valid), 32'd1);
    check("late_ack_idata", idata,            32'hDEAD_BEEF);

    do_retire(32'h102);
    check("mis_fault", 32'(misalign_fault), 32'd1);
    check("mis_faddr", fault_addr,          32'h102);
    repeat (3) begin
      tick();
      check("mis_noreq", 32'(imem_req), 32'd0);
    end

    do_reset();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("midreq_rst_req", 32'(imem_req),       32'd0);
    check("midreq_rst_mis", 32'(misalign_fault), 32'd0);
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    check("ign_ack_valid", 32'(instr_valid), 32'd0);
    check("ign_ack_req",   32'(imem_req),    32'd1);
    check("ign_ack_addr",  imem_addr,        32'h0);

    ack_pct = 50;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 250 == 0) begin
        case ($urandom_range(3))
          0:       ack_pct = 3;
          1:       ack_pct = 15;
          2:       ack_pct = 50;
          default: ack_pct = 100;
        endcase
      end
      imem_ack    = ($urandom_range(99) < ack_pct);
      imem_rdata  = $urandom;
      instr_ready = 1'($urandom_range(1));
      rnd         = $urandom;
      iaddr_val   = {rnd[31:2], 2'b00};
      if ($urandom_range(31) == 0) iaddr_val[1:0] = 2'($urandom_range(3, 1));
      if (m_ff || m_mf) reset = ($urandom_range(3) == 0);
      else              reset = ($urandom_range(499) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
